// File: rtl/decode_hazard_unit_if.sv
// Fetch/writeback/branch inputs and DE/EX latch outputs of the decode hazard unit.
interface decode_hazard_unit_if #(
    parameter int PC_WIDTH = 16,
    parameter int IR_WIDTH = 32
);
    logic                I_LOCK;
    logic [PC_WIDTH-1:0] I_PC;
    logic [IR_WIDTH-1:0] I_IR;
    logic                I_FetchStall;
    logic                I_WBValid;
    logic [3:0]          I_WBReg;
    logic                I_BranchResolve;

    logic                O_LOCK;
    logic [PC_WIDTH-1:0] O_PC;
    logic [IR_WIDTH-1:0] O_IR;
    logic                O_Valid;
    logic                O_BranchStallSignal;
    logic                O_DepStallSignal;

    modport master (
        output I_LOCK, I_PC, I_IR, I_FetchStall, I_WBValid, I_WBReg, I_BranchResolve,
        input  O_LOCK, O_PC, O_IR, O_Valid, O_BranchStallSignal, O_DepStallSignal
    );

    modport slave (
        input  I_LOCK, I_PC, I_IR, I_FetchStall, I_WBValid, I_WBReg, I_BranchResolve,
        output O_LOCK, O_PC, O_IR, O_Valid, O_BranchStallSignal, O_DepStallSignal
    );
endinterface

// File: rtl/decode_hazard_unit.sv
// Decode-stage hazard unit: register scoreboard, dependency stall and branch wait,
// driving a registered DE/EX latch.
module decode_hazard_unit #(
    parameter int PC_WIDTH = 16,
    parameter int IR_WIDTH = 32,
    parameter int NUM_REGS = 16
) (
    input logic                 I_CLOCK,
    input logic                 I_RESET,
    decode_hazard_unit_if.slave bus
);
    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] DEP_STALL = 2'd1;
    localparam logic [1:0] BR_WAIT   = 2'd2;

    localparam logic [IR_WIDTH-1:0] NOP_IR = IR_WIDTH'(32'hFF000000);

    logic [1:0]          state_q, state_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [PC_WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic [IR_WIDTH-1:0] hold_ir_q, hold_ir_d;
    logic                lock_q;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                valid_q, valid_d;
    logic                br_stall_q, br_stall_d;
    logic                dep_stall_q, dep_stall_d;

    logic                cand_valid;
    logic [PC_WIDTH-1:0] cand_pc;
    logic [IR_WIDTH-1:0] cand_ir;
    logic                is_nop, is_branch, is_store;
    logic                reads_rs1, reads_rs2, writes_rd;
    logic [NUM_REGS-1:0] rd_mask, rs1_mask, rs2_mask, wb_mask, eff_busy;
    logic                hazard;
    logic                unused_ir_bits;

    // The held instruction always takes precedence over fetch while dependency-stalled.
    assign cand_valid = (state_q == DEP_STALL) ||
                        (state_q == RUN && bus.I_LOCK && !bus.I_FetchStall);
    assign cand_pc    = (state_q == DEP_STALL) ? hold_pc_q : bus.I_PC;
    assign cand_ir    = (state_q == DEP_STALL) ? hold_ir_q : bus.I_IR;

    assign is_nop    = (cand_ir[31:24] == 8'hFF);
    assign is_branch = (cand_ir[31:28] == 4'h2);
    assign is_store  = (cand_ir[31:28] == 4'h1);
    assign reads_rs1 = !is_nop;
    assign reads_rs2 = !is_nop && !is_branch;
    assign writes_rd = !is_nop && !is_branch && !is_store;

    assign rd_mask  = NUM_REGS'(1) << cand_ir[23:20];
    assign rs1_mask = NUM_REGS'(1) << cand_ir[19:16];
    assign rs2_mask = NUM_REGS'(1) << cand_ir[11:8];
    assign wb_mask  = bus.I_WBValid ? (NUM_REGS'(1) << bus.I_WBReg) : '0;
    assign eff_busy = busy_q & ~wb_mask;

    assign hazard = (reads_rs1 && |(eff_busy & rs1_mask)) ||
                    (reads_rs2 && |(eff_busy & rs2_mask)) ||
                    (writes_rd && |(eff_busy & rd_mask));

    assign unused_ir_bits = ^{cand_ir[15:12], cand_ir[7:0]};

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        hold_pc_d   = hold_pc_q;
        hold_ir_d   = hold_ir_q;
        pc_d        = pc_q;
        ir_d        = NOP_IR;
        valid_d     = 1'b0;
        br_stall_d  = br_stall_q;
        dep_stall_d = dep_stall_q;

        // With the pipeline disabled everything but the latch valid/IR freezes.
        if (bus.I_LOCK) begin
            busy_d = eff_busy;
            if (state_q == BR_WAIT) begin
                br_stall_d = 1'b1;
                if (bus.I_BranchResolve) begin
                    state_d    = RUN;
                    br_stall_d = 1'b0;
                end
            end else if (cand_valid) begin
                br_stall_d = is_branch;
                if (!hazard) begin
                    pc_d        = cand_pc;
                    ir_d        = cand_ir;
                    valid_d     = 1'b1;
                    dep_stall_d = 1'b0;
                    state_d     = is_branch ? BR_WAIT : RUN;
                    if (writes_rd) begin
                        busy_d = eff_busy | rd_mask;
                    end
                end else begin
                    hold_pc_d   = cand_pc;
                    hold_ir_d   = cand_ir;
                    dep_stall_d = 1'b1;
                    state_d     = DEP_STALL;
                end
            end else begin
                br_stall_d  = 1'b0;
                dep_stall_d = 1'b0;
            end
        end
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            state_q     <= RUN;
            busy_q      <= '0;
            hold_pc_q   <= '0;
            hold_ir_q   <= '0;
            lock_q      <= 1'b0;
            pc_q        <= '0;
            ir_q        <= NOP_IR;
            valid_q     <= 1'b0;
            br_stall_q  <= 1'b0;
            dep_stall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            hold_pc_q   <= hold_pc_d;
            hold_ir_q   <= hold_ir_d;
            lock_q      <= bus.I_LOCK;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            valid_q     <= valid_d;
            br_stall_q  <= br_stall_d;
            dep_stall_q <= dep_stall_d;
        end
    end

    assign bus.O_LOCK              = lock_q;
    assign bus.O_PC                = pc_q;
    assign bus.O_IR                = ir_q;
    assign bus.O_Valid             = valid_q;
    assign bus.O_BranchStallSignal = br_stall_q;
    assign bus.O_DepStallSignal    = dep_stall_q;
endmodule
